// File: rtl/audio_pkg.sv
// Shared constants for the speaker output path.
// Every divided clock and the input-latch point are derived from a single
// free-running 9-bit frame counter.
package audio_pkg;

    // Frame counter width; one I2S frame is 2**CNT_W system clocks
    localparam int CNT_W    = 9;
    // Sample width per channel
    localparam int DATA_W   = 16;

    // Counter bits that are driven out directly as DAC clocks
    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 8;

    // Counter value during which new samples are taken from upstream
    localparam logic [CNT_W-1:0] LATCH_CNT = 9'd511;

    // Sample bit carried in SCK period k (1..15) of a half-frame.
    // The one-period I2S delay means period k carries bit 16-k.
    function automatic logic [3:0] msb_index(input logic [3:0] k);
        return 4'(5'd16 - {1'b0, k});
    endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Frame counter and derived DAC clocks.
// All clock outputs come straight from counter flops, so they are glitch-free
// and are all forced low while reset is asserted.
module audio_clk_gen
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt_next,
    output logic             audio_mclk,
    output logic             audio_sck,
    output logic             audio_lrck,
    output logic             sample_tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next counter value (wraps 511->0) and the latch-cycle flag for that value
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = (cnt_d == LATCH_CNT);
    end

    // Counter and tick registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign cnt_next    = cnt_d;
    assign audio_mclk  = cnt_q[MCLK_BIT];
    assign audio_sck   = cnt_q[SCK_BIT];
    assign audio_lrck  = cnt_q[LRCK_BIT];
    assign sample_tick = tick_q;

endmodule

// File: rtl/speaker_ctrl.sv
// I2S transmitter for a stereo DAC.
// Samples are captured once per frame at the latch cycle and then streamed
// MSB first with the usual one-SCK delay after each word-select change.
// Only DATA_W == 16 is meaningful; the bit-index arithmetic assumes it.
module speaker_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] audio_in_left,
    input  logic [DATA_W-1:0] audio_in_right,
    input  logic              mute,
    output logic              audio_mclk,
    output logic              audio_lrck,
    output logic              audio_sck,
    output logic              audio_sdin,
    output logic              sample_tick
);
    import audio_pkg::*;

    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] left_d;
    logic [DATA_W-1:0] right_q;
    logic [DATA_W-1:0] right_d;
    logic              sdin_q;
    logic              sdin_d;
    logic [3:0]        next_k;
    logic              next_h;

    audio_clk_gen u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_next    (cnt_next),
        .audio_mclk  (audio_mclk),
        .audio_sck   (audio_sck),
        .audio_lrck  (audio_lrck),
        .sample_tick (sample_tick)
    );

    // Holding registers: load new samples (or silence) only at the latch cycle
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        if (sample_tick) begin
            if (mute) begin
                left_d  = '0;
                right_d = '0;
            end else begin
                left_d  = audio_in_left;
                right_d = audio_in_right;
            end
        end
    end

    // Serial bit for the SCK period that starts on the next edge.
    // At the frame wrap the holding registers are reloaded on the same edge,
    // so the old right LSB is still visible here for left-half period 0.
    always_comb begin
        sdin_d = sdin_q;
        next_k = cnt_next[LRCK_BIT-1:SCK_BIT+1];
        next_h = cnt_next[LRCK_BIT];
        if (cnt_next[SCK_BIT:0] == '0) begin
            if (next_k == 4'd0) begin
                sdin_d = next_h ? left_q[0] : right_q[0];
            end else if (next_h) begin
                sdin_d = right_q[msb_index(next_k)];
            end else begin
                sdin_d = left_q[msb_index(next_k)];
            end
        end
    end

    // Sample holding and serial output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q  <= '0;
            right_q <= '0;
            sdin_q  <= 1'b0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            sdin_q  <= sdin_d;
        end
    end

    assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_speaker_ctrl.sv
// Self-checking bench for speaker_ctrl.
// A frame-level reference model tracks which samples each frame carries and
// predicts every output each cycle; decoded words are also compared against
// a table of expected frame contents.
module tb_speaker_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] audio_in_left = 16'h0;
    logic [15:0] audio_in_right = 16'h0;
    logic        mute = 1'b0;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;
    logic        sample_tick;

    speaker_ctrl #(.DATA_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .audio_in_left  (audio_in_left),
        .audio_in_right (audio_in_right),
        .mute           (mute),
        .audio_mclk     (audio_mclk),
        .audio_lrck     (audio_lrck),
        .audio_sck      (audio_sck),
        .audio_sdin     (audio_sdin),
        .sample_tick    (sample_tick)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        m;
        logic [15:0] midL;
        logic [15:0] midR;
        logic        midM;
        logic [15:0] expL;
        logic [15:0] expR;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs[NVEC];

    int checks = 0;
    int errors = 0;
    int t = 0;

    // Words carried by each frame since the last reset release (frame 0 = zeros)
    logic [15:0] heldL[$];
    logic [15:0] heldR[$];

    // Words recovered from audio_sdin, indexed by frame
    logic [15:0] decL[64];
    logic [15:0] decR[64];

    int   lastMclkRise, lastSckRise, lastLrckRise, lastTickRise;
    logic prevMclk, prevSck, prevLrck, prevTick;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s t=%0d actual=%0h expected=%0h", name, t, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input logic m);
        audio_in_left  = l;
        audio_in_right = r;
        mute           = m;
    endtask

    // Expected serial bit in cycle tt of the current reset epoch
    function automatic logic expSdin(input int tt);
        int f, pos, half, k;
        logic [15:0] w;
        f    = tt / 512;
        pos  = tt % 512;
        half = pos / 256;
        k    = (pos % 256) / 16;
        if (k == 0) begin
            if (half == 1) begin
                w = heldL[f];
                return w[0];
            end
            if (f == 0) return 1'b0;
            w = heldR[f-1];
            return w[0];
        end
        w = (half == 1) ? heldR[f] : heldL[f];
        return w[16-k];
    endfunction

    task automatic checkModel();
        int pos;
        pos = t % 512;
        checkOutput("mclk", audio_mclk, (pos / 2) % 2);
        checkOutput("sck", audio_sck, (pos / 8) % 2);
        checkOutput("lrck", audio_lrck, pos / 256);
        checkOutput("sample_tick", sample_tick, (pos == 511) ? 1 : 0);
        checkOutput("sdin", audio_sdin, expSdin(t));
    endtask

    task automatic trackPeriods();
        if (audio_mclk && !prevMclk) begin
            if (lastMclkRise >= 0) checkOutput("mclk_period", t - lastMclkRise, 4);
            lastMclkRise = t;
        end
        if (audio_sck && !prevSck) begin
            if (lastSckRise >= 0) checkOutput("sck_period", t - lastSckRise, 16);
            lastSckRise = t;
        end
        if (audio_lrck && !prevLrck) begin
            if (lastLrckRise >= 0) checkOutput("lrck_period", t - lastLrckRise, 512);
            lastLrckRise = t;
        end
        if (!audio_lrck && prevLrck && lastLrckRise >= 0) begin
            checkOutput("lrck_high", t - lastLrckRise, 256);
        end
        if (sample_tick && !prevTick) begin
            if (lastTickRise >= 0) checkOutput("tick_period", t - lastTickRise, 512);
            lastTickRise = t;
        end
        if (!sample_tick && prevTick) begin
            checkOutput("tick_width", t - lastTickRise, 1);
        end
        prevMclk = audio_mclk;
        prevSck  = audio_sck;
        prevLrck = audio_lrck;
        prevTick = sample_tick;
    endtask

    // Sample sdin mid-period and file the bit under the word it belongs to
    task automatic recordBit();
        int f, pos, half, k;
        f    = t / 512;
        pos  = t % 512;
        half = pos / 256;
        k    = (pos % 256) / 16;
        if (pos % 16 == 8 && f < 64) begin
            if (half == 0 && k == 0) begin
                if (f > 0) decR[f-1][0] = audio_sdin;
            end else if (half == 0) begin
                decL[f][16-k] = audio_sdin;
            end else if (k == 0) begin
                decL[f][0] = audio_sdin;
            end else begin
                decR[f][16-k] = audio_sdin;
            end
        end
    endtask

    task automatic advanceCycle();
        if (t % 512 == 511) begin
            heldL.push_back(mute ? 16'h0000 : audio_in_left);
            heldR.push_back(mute ? 16'h0000 : audio_in_right);
        end
        @(posedge clk);
        #1;
        t++;
        checkModel();
        trackPeriods();
        recordBit();
    endtask

    task automatic runTo(input int pos);
        while (t % 512 != pos) advanceCycle();
    endtask

    task automatic startEpoch();
        t = 0;
        heldL.delete();
        heldR.delete();
        heldL.push_back(16'h0000);
        heldR.push_back(16'h0000);
        for (int i = 0; i < 64; i++) begin
            decL[i] = 16'hDEAD;
            decR[i] = 16'hDEAD;
        end
        lastMclkRise = -1;
        lastSckRise  = -1;
        lastLrckRise = -1;
        lastTickRise = -1;
        prevMclk = audio_mclk;
        prevSck  = audio_sck;
        prevLrck = audio_lrck;
        prevTick = sample_tick;
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, "_mclk"}, audio_mclk, 0);
        checkOutput({tag, "_sck"}, audio_sck, 0);
        checkOutput({tag, "_lrck"}, audio_lrck, 0);
        checkOutput({tag, "_sdin"}, audio_sdin, 0);
        checkOutput({tag, "_tick"}, sample_tick, 0);
    endtask

    initial begin
        vecs[0] = '{16'hA5A5, 16'h0F0F, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'hA5A5, 16'h0F0F};
        vecs[1] = '{16'h7FFF, 16'h8000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[2] = '{16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h7FFF, 16'h8000};
        vecs[3] = '{16'h1234, 16'h1234, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h1234, 16'h1234};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[5] = '{16'h8000, 16'h7FFF, 1'b0, 16'h5555, 16'hAAAA, 1'b0, 16'h8000, 16'h7FFF};
        vecs[6] = '{16'h0001, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001, 16'hFFFE};
        vecs[7] = '{16'h5A5A, 16'hC3C3, 1'b1, 16'h1111, 16'h2222, 1'b0, 16'h0000, 16'h0000};

        // Reset held: everything low even with clocks running
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkAllLow("reset");

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        startEpoch();
        checkModel();

        // Table phase: vecs[i] is latched at the end of frame i and carried by frame i+1;
        // its mid values are applied at cnt==100 of frame i+1 and must not leak in
        for (int i = 0; i <= NVEC; i++) begin
            runTo(100);
            if (i > 0) applyStimulus(vecs[i-1].midL, vecs[i-1].midR, vecs[i-1].midM);
            if (i < NVEC) begin
                runTo(500);
                applyStimulus(vecs[i].l, vecs[i].r, vecs[i].m);
            end
            runTo(511);
        end
        runTo(20);

        checkOutput("frame0_left", decL[0], 16'h0000);
        checkOutput("frame0_right", decR[0], 16'h0000);
        for (int i = 0; i < NVEC; i++) begin
            checkOutput($sformatf("vec%0d_left", i), decL[i+1], vecs[i].expL);
            checkOutput($sformatf("vec%0d_right", i), decR[i+1], vecs[i].expR);
        end

        // Random phase: inputs and mute change every cycle, model predicts all outputs
        repeat (6 * 512) begin
            applyStimulus(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
            advanceCycle();
        end

        // Mid-frame reset at cnt==300: outputs must drop before the next edge
        runTo(300);
        rst_n = 1'b0;
        #1;
        checkAllLow("async_reset");
        @(posedge clk);
        #1;
        checkAllLow("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        startEpoch();
        checkModel();
        applyStimulus(16'h3C3C, 16'hC3C3, 1'b0);
        runTo(511);
        advanceCycle();
        runTo(511);
        runTo(20);

        checkOutput("post_reset_frame0_left", decL[0], 16'h0000);
        checkOutput("post_reset_frame0_right", decR[0], 16'h0000);
        checkOutput("post_reset_frame1_left", decL[1], 16'h3C3C);
        checkOutput("post_reset_frame1_right", decR[1], 16'hC3C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
